rom_streamer: RTL and testbench

Sequencer sitting directly upstream of `rom_sync`: on a start command it walks a contiguous address range, drives the ROM's `address`/`read_en`/`ce` inputs, and captures the returned bytes. It re-emits them as a valid/ready byte stream with a last-beat marker. A 2-entry output buffer absorbs the ROM's 1-cycle read latency so downstream backpressure never drops data.

---
 rtl/rom_streamer_pkg.sv | 20 ++
 rtl/rom_streamer_fifo.sv | 60 ++++++
 rtl/rom_streamer.sv | 166 ++++++++++++++++
 tb/tb_rom_streamer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_streamer_pkg.sv
// Shared types and constants for the ROM streamer.
// Contents: default widths, output buffer depth, occupancy width, FSM state type.
package rom_streamer_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_LEN_W  = 9;

    // Two entries cover one beat sitting at the head plus one read in flight.
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/rom_streamer_fifo.sv
// Two-entry synchronous FIFO holding ROM bytes plus their last-beat flag.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   push, push_data/last   write side; caller guarantees space
//   pop                    read side; ignored while empty
//   head_data/last/valid   current head entry
//   occ                    number of stored entries (0..FIFO_DEPTH)
module rom_streamer_fifo
    import rom_streamer_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic              head_valid,
    output logic [OCC_W-1:0]  occ
);

    logic [DATA_W-1:0] data_q [FIFO_DEPTH];
    logic              last_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;
    logic              pop_ok;

    assign pop_ok     = pop && (occ_q != '0);
    assign head_valid = (occ_q != '0);
    assign head_data  = data_q[rd_ptr_q];
    // Last flag only shows while the head is real data.
    assign head_last  = last_q[rd_ptr_q] && head_valid;
    assign occ        = occ_q;

    // Storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '{default: '0};
            last_q   <= '{default: 1'b0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= push_data;
                last_q[wr_ptr_q] <= push_last;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop_ok);
        end
    end

endmodule

// File: rtl/rom_streamer.sv
// Walks a contiguous ROM address range on command and re-emits the bytes
// as a valid/ready stream with a last-beat marker.
// Optional feature macro: ROM_STREAMER_CHECKSUM_EN (running byte sum on checksum).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start, base_addr, length         command; sampled only while idle
//   busy, done                       command in progress / end-of-command pulse
//   rom_address, rom_read_en, rom_ce ROM request side
//   rom_data                         ROM data, valid the cycle after a read
//   out_data, out_valid, out_ready,
//   out_last                         output byte stream
//   checksum                         sum of transferred beats, or 0
module rom_streamer
    import rom_streamer_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_read_en,
    output logic              rom_ce,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [DATA_W-1:0] checksum
);

    localparam int unsigned PEND_W = OCC_W + 1;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic              inf_q;
    logic              inf_last_q;
    logic              done_q;
    logic [OCC_W-1:0]  occ;
    logic              pop_c;
    logic [PEND_W-1:0] pend_c;
    logic              accept_c;
    logic              issue_c;
    logic              last_issue_c;
    logic              drained_c;

    assign pop_c  = out_valid && out_ready;
    // Entries that will still be held after this cycle's pop, counting the read in flight.
    assign pend_c = PEND_W'(occ) + PEND_W'(inf_q) - PEND_W'(pop_c);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_d      = state_q;
        accept_c     = 1'b0;
        issue_c      = 1'b0;
        last_issue_c = 1'b0;
        drained_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    if (length != '0) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (pend_c < PEND_W'(FIFO_DEPTH)) begin
                    issue_c = 1'b1;
                    if (remain_q == LEN_W'(1)) begin
                        last_issue_c = 1'b1;
                        state_d      = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inf_q && (pend_c == '0)) begin
                    drained_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address/count walker, read-in-flight tracking and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            remain_q   <= '0;
            inf_q      <= 1'b0;
            inf_last_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inf_q      <= issue_c;
            inf_last_q <= last_issue_c;
            done_q     <= drained_c || (accept_c && (length == '0));
            if (accept_c && (length != '0)) begin
                addr_q   <= base_addr;
                remain_q <= length;
            end else if (issue_c) begin
                addr_q   <= addr_q + ADDR_W'(1);
                remain_q <= remain_q - LEN_W'(1);
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign rom_ce      = busy;
    assign rom_read_en = issue_c;
    assign rom_address = addr_q;
    assign done        = done_q;

    // ROM data lands in the buffer unconditionally; credit check guarantees room.
    rom_streamer_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inf_q),
        .push_data  (rom_data),
        .push_last  (inf_last_q),
        .pop        (pop_c),
        .head_data  (out_data),
        .head_last  (out_last),
        .head_valid (out_valid),
        .occ        (occ)
    );

`ifdef ROM_STREAMER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    // Running sum of transferred beats; cleared by each accepted command.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (accept_c) begin
            sum_q <= '0;
        end else if (pop_c) begin
            sum_q <= sum_q + out_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_streamer.sv
// Self-checking bench for rom_streamer with a queue-based stream model.
module tb_rom_streamer;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_address;
    logic          rom_read_en;
    logic          rom_ce;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [DW-1:0] checksum;

    rom_streamer #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .rom_address (rom_address),
        .rom_read_en (rom_read_en),
        .rom_ce      (rom_ce),
        .rom_data    (rom_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM behaviour: one-cycle registered read.
    logic [DW-1:0] rom_mem [256];
    always @(posedge clk) begin
        if (rst) rom_data <= '0;
        else if (rom_ce && rom_read_en) rom_data <= rom_mem[rom_address];
    end

    // Model: expected reads and beats, in address order.
    logic [AW-1:0] exp_addr [$];
    logic [DW:0]   exp_beats [$];
    logic [DW-1:0] seen [$];
    logic [DW-1:0] exp_sum;
    logic [DW-1:0] chk_at_done;
    int t0, first_beat_cyc, last_beat_cyc, done_cyc;
    int ready_mode = 0;
    int pat_i = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Downstream ready: always, fixed 1,0,0,1 pattern, or random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
                    pat_i++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Per-cycle compare against the model.
    initial begin
        logic prev_held;
        logic prev_done;
        logic [DW-1:0] prev_data;
        logic prev_last;
        prev_held = 1'b0;
        prev_done = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_held = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (rom_read_en) begin
                    check("rom_ce_on_read", 32'(rom_ce), 32'd1);
                    check("read_expected", 32'(exp_addr.size() != 0), 32'd1);
                    if (exp_addr.size() != 0) check("rom_address", 32'(rom_address), 32'(exp_addr.pop_front()));
                end
                if (prev_held) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(out_data), 32'(prev_data));
                    check("hold_last", 32'(out_last), 32'(prev_last));
                end
                if (out_valid) begin
                    check("beat_expected", 32'(exp_beats.size() != 0), 32'd1);
                    if (exp_beats.size() != 0) begin
                        check("out_data", 32'(out_data), 32'(exp_beats[0][DW-1:0]));
                        check("out_last", 32'(out_last), 32'(exp_beats[0][DW]));
                        if (out_ready) begin
                            exp_sum = exp_sum + exp_beats[0][DW-1:0];
                            seen.push_back(out_data);
                            if (first_beat_cyc < 0) first_beat_cyc = cyc;
                            last_beat_cyc = cyc;
                            void'(exp_beats.pop_front());
                        end
                    end
                end else begin
                    check("last_without_valid", 32'(out_last), 32'd0);
                end
                if (prev_done) check("done_one_cycle", 32'(done), 32'd0);
                if (done) begin
                    check("busy_at_done", 32'(busy), 32'd0);
                    if (done_cyc < 0) begin
                        done_cyc    = cyc;
                        chk_at_done = checksum;
                    end
                end
                prev_done = done;
                prev_held = out_valid && !out_ready;
                prev_data = out_data;
                prev_last = out_last;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rom_address"}, 32'(rom_address), 32'd0);
        check({tag, "_rom_read_en"}, 32'(rom_read_en), 32'd0);
        check({tag, "_rom_ce"}, 32'(rom_ce), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_checksum"}, 32'(checksum), 32'd0);
    endtask

    // Issue one command, optionally with an ignored second start at cycle extra_at.
    task automatic run_cmd(input int base, input int len, input bit chk_timing, input int extra_at);
        int bound;
        @(posedge clk);
        #1;
        exp_sum = '0;
        first_beat_cyc = -1;
        last_beat_cyc = -1;
        done_cyc = -1;
        for (int i = 0; i < len; i++) begin
            exp_addr.push_back(AW'(base + i));
            exp_beats.push_back({1'(i == len - 1), rom_mem[AW'(base + i)]});
        end
        start = 1'b1;
        base_addr = AW'(base);
        length = LW'(len);
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = AW'($urandom);
        length = LW'($urandom_range(0, 300));
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'(len != 0));
        if (extra_at > 1) begin
            repeat (extra_at - 1) @(posedge clk);
            #1;
            start = 1'b1;
            base_addr = AW'(base + 77);
            length = LW'(3);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        bound = len * 6 + 40;
        for (int k = 0; k < bound && done_cyc < 0; k++) @(posedge clk);
        check("done_seen", 32'(done_cyc >= 0), 32'd1);
        check("beats_left", 32'(exp_beats.size()), 32'd0);
        check("reads_left", 32'(exp_addr.size()), 32'd0);
        exp_beats.delete();
        exp_addr.delete();
        if (chk_timing && done_cyc >= 0) begin
            if (len > 0) begin
                check("first_beat_cycle", 32'(first_beat_cyc - t0), 32'd3);
                check("last_beat_cycle", 32'(last_beat_cyc - t0), 32'(len + 2));
                check("done_cycle", 32'(done_cyc - t0), 32'(len + 3));
            end else begin
                check("zero_len_done_cycle", 32'(done_cyc - t0), 32'd1);
            end
        end
`ifdef ROM_STREAMER_CHECKSUM_EN
        check("checksum_at_done", 32'(chk_at_done), 32'(exp_sum));
        @(negedge clk);
        check("checksum_hold", 32'(checksum), 32'(exp_sum));
`else
        check("checksum_at_done", 32'(chk_at_done), 32'd0);
`endif
    endtask

    // Ten-beat command with reset asserted in cycle 5.
    task automatic reset_mid;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            exp_addr.push_back(AW'(60 + i));
            exp_beats.push_back({1'(i == 9), rom_mem[AW'(60 + i)]});
        end
        start = 1'b1;
        base_addr = AW'(60);
        length = LW'(10);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_addr.delete();
        exp_beats.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("mid_reset");
        repeat (12) @(posedge clk);
    endtask

    initial begin
        int len;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        length = '0;
        exp_sum = '0;
        chk_at_done = '0;
        first_beat_cyc = -1;
        last_beat_cyc = -1;
        done_cyc = -1;
        for (int i = 0; i < 256; i++) rom_mem[i] = DW'(i);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("reset");
        repeat (20) @(posedge clk);

        // Basic read, identity ROM.
        seen.delete();
        run_cmd(0, 4, 1'b1, 0);
        check("basic_count", 32'(seen.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++) check("basic_beat", 32'(seen[i]), 32'(i));

        // Address wrap.
        seen.delete();
        run_cmd(254, 4, 1'b1, 0);
        check("wrap_count", 32'(seen.size()), 32'd4);
        if (seen.size() == 4) begin
            check("wrap_beat0", 32'(seen[0]), 32'd254);
            check("wrap_beat1", 32'(seen[1]), 32'd255);
            check("wrap_beat2", 32'(seen[2]), 32'd0);
            check("wrap_beat3", 32'(seen[3]), 32'd1);
        end
`ifdef ROM_STREAMER_CHECKSUM_EN
        check("wrap_checksum_literal", 32'(chk_at_done), 32'd254);
`endif

        // Backpressure 1,0,0,1.
        seen.delete();
        pat_i = 0;
        ready_mode = 1;
        run_cmd(16, 8, 1'b0, 0);
        check("bp_count", 32'(seen.size()), 32'd8);
        ready_mode = 0;
        repeat (2) @(posedge clk);

        // Zero length, then start while busy.
        seen.delete();
        run_cmd(5, 0, 1'b1, 0);
        check("zero_len_beats", 32'(seen.size()), 32'd0);
        seen.delete();
        run_cmd(100, 5, 1'b1, 2);
        check("busy_start_count", 32'(seen.size()), 32'd5);

        // Reset mid-command, then a fresh command.
        seen.delete();
        reset_mid();
        check("mid_reset_beats", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            check("mid_reset_beat0", 32'(seen[0]), 32'd60);
            check("mid_reset_beat1", 32'(seen[1]), 32'd61);
        end
        run_cmd(40, 6, 1'b1, 0);

        // Randomized commands over random ROM contents.
        for (int i = 0; i < 256; i++) rom_mem[i] = DW'($urandom);
        for (int k = 0; k < 24; k++) begin
            ready_mode = int'($urandom_range(0, 2));
            pat_i = 0;
            len = (k == 10) ? 256 : ((k % 7) == 3) ? 0 : int'($urandom_range(1, 24));
            seen.delete();
            run_cmd(int'($urandom_range(0, 255)), len, ready_mode == 0, 0);
            check("rand_count", 32'(seen.size()), 32'(len));
            repeat (int'($urandom_range(0, 3))) @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
